ternary_mac_neuron: RTL and testbench

Sequential ternary neuron for the layer-1 datapath. Accumulates N_INPUTS products of 2-bit ternary inputs and weights, one per cycle, then adds a signed 4-bit bias and presents a 7-bit signed pre-activation plus a ternary sign activation. The parent layer FSM reuses one instance for every neuron. The parent indexes its pixel and weight ROMs with mac_count_out, so operands arrive combinationally in the same cycle the count is presented.

---
 rtl/ternary_mac_neuron_pkg.sv | 28 ++
 rtl/ternary_mac_neuron_if.sv | 26 ++
 rtl/ternary_mac_neuron_sign.sv | 16 +
 rtl/ternary_mac_neuron.sv | 94 +++++++++
 tb/tb_ternary_mac_neuron.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ternary_mac_neuron_pkg.sv
// Shared types and helpers for the sequential ternary neuron.
// Product helper treats the illegal code 2'b10 as zero.
package neuron_pkg;

  localparam int ACC_W = 8;
  localparam int RES_W = 7;

  localparam logic [1:0] TERN_ZERO = 2'b00;
  localparam logic [1:0] TERN_POS  = 2'b01;
  localparam logic [1:0] TERN_NEG  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    BIAS = 2'd2
  } state_t;

  function automatic logic signed [ACC_W-1:0] tern_product(input logic [1:0] a,
                                                           input logic [1:0] b);
    logic a_nz;
    logic b_nz;
    a_nz = (a == TERN_POS) || (a == TERN_NEG);
    b_nz = (b == TERN_POS) || (b == TERN_NEG);
    if (!(a_nz && b_nz)) return '0;
    return (a == b) ? ACC_W'(1) : '1;
  endfunction

endpackage

// File: rtl/ternary_mac_neuron_if.sv
// Handshake/operand bundle between the layer FSM (master) and the neuron (slave).
interface ternary_mac_neuron_if #(
  parameter int N_INPUTS = 64,
  parameter int RES_W    = 7
);
  localparam int CNT_W = $clog2(N_INPUTS);

  logic             start;
  logic [1:0]       input_val;
  logic [1:0]       weight;
  logic [3:0]       bias;
  logic             done;
  logic [RES_W-1:0] result;
  logic [1:0]       act;
  logic [CNT_W-1:0] mac_count_out;

  modport master (
    output start, input_val, weight, bias,
    input  done, result, act, mac_count_out
  );

  modport slave (
    input  start, input_val, weight, bias,
    output done, result, act, mac_count_out
  );
endinterface

// File: rtl/ternary_mac_neuron_sign.sv
// Ternary sign of a signed value; drives the neuron's act output and is reusable by the parent.
module ternary_sign #(
  parameter int W = 7
) (
  input  logic signed [W-1:0] value,
  output logic [1:0]          act
);
  import neuron_pkg::*;

  always_comb begin
    act = TERN_ZERO;
    if (value == '0)      act = TERN_ZERO;
    else if (value[W-1])  act = TERN_NEG;
    else                  act = TERN_POS;
  end
endmodule

// File: rtl/ternary_mac_neuron.sv
// Sequential ternary MAC neuron: N_INPUTS ternary products, bias add, narrowed result.
// Build option NEURON_SATURATE_EN clamps the result instead of wrapping it.
//
// state | meaning
// IDLE  | waiting for start; count held at 0
// MAC   | one product accumulated per cycle, operands indexed by mac_count_out
// BIAS  | bias added, result registered, done pulsed next cycle
module ternary_mac_neuron #(
  parameter int N_INPUTS = 64,
  parameter int RES_W    = 7
) (
  input logic clk,
  input logic rst_n,
  ternary_mac_neuron_if.slave nif
);
  import neuron_pkg::*;

  localparam int CNT_W = $clog2(N_INPUTS);
  localparam logic signed [ACC_W-1:0] RES_MAX = ACC_W'((1 <<< (RES_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] RES_MIN = ~RES_MAX;

  state_t                  state, state_next;
  logic signed [ACC_W-1:0] acc, acc_next;
  logic [CNT_W-1:0]        count, count_next;
  logic                    done_q, done_next;
  logic [RES_W-1:0]        result_q, result_next;
  logic signed [ACC_W-1:0] acc_final;
  logic signed [ACC_W-1:0] acc_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state    <= state_next;
      acc      <= acc_next;
      count    <= count_next;
      done_q   <= done_next;
      result_q <= result_next;
    end
  end

  always_comb begin
    state_next  = state;
    acc_next    = acc;
    count_next  = count;
    done_next   = 1'b0;
    result_next = result_q;
    acc_final   = acc + $signed({{(ACC_W-4){nif.bias[3]}}, nif.bias});
    acc_sat     = acc_final;
`ifdef NEURON_SATURATE_EN
    if (acc_final > RES_MAX)      acc_sat = RES_MAX;
    else if (acc_final < RES_MIN) acc_sat = RES_MIN;
`endif

    case (state)
      IDLE: begin
        if (nif.start) begin
          acc_next   = '0;
          count_next = '0;
          state_next = MAC;
        end
      end
      MAC: begin
        acc_next = acc + tern_product(nif.input_val, nif.weight);
        if (count == CNT_W'(N_INPUTS - 1)) begin
          count_next = '0;
          state_next = BIAS;
        end else begin
          count_next = count + 1'b1;
        end
      end
      BIAS: begin
        // Without saturation the truncation is the intended two's-complement wrap.
        result_next = RES_W'(acc_sat);
        done_next   = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign nif.done          = done_q;
  assign nif.result        = result_q;
  assign nif.mac_count_out = count;

  ternary_sign #(.W(RES_W)) u_sign (
    .value (result_q),
    .act   (nif.act)
  );
endmodule

// File: tb/tb_ternary_mac_neuron.sv
// Randomized and directed checks of ternary_mac_neuron against a behavioural model.
module tb_ternary_mac_neuron;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ternary_mac_neuron_if #(.N_INPUTS(64), .RES_W(7)) nif ();

  ternary_mac_neuron #(.N_INPUTS(64), .RES_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .nif   (nif)
  );

  logic [1:0] in_mem [64];
  logic [1:0] w_mem  [64];

  // Operand ROMs answer combinationally to the presented index.
  assign nif.input_val = in_mem[nif.mac_count_out];
  assign nif.weight    = w_mem[nif.mac_count_out];

  int         cmp_count = 0;
  int         err_count = 0;
  int         cnt_log[$];
  logic [6:0] glitch_result;
  int         last_exp;

  function automatic int tval(input logic [1:0] c);
    case (c)
      2'b01:   return 1;
      2'b11:   return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int model_acc(input int b);
    int s;
    s = b;
    for (int i = 0; i < 64; i++) s += tval(in_mem[i]) * tval(w_mem[i]);
    return s;
  endfunction

  function automatic int model_res(input int a);
    int r;
`ifdef NEURON_SATURATE_EN
    r = (a > 63) ? 63 : (a < -64) ? -64 : a;
`else
    r = ((a % 128) + 128) % 128;
    if (r >= 64) r -= 128;
`endif
    return r;
  endfunction

  function automatic logic [1:0] model_act(input int r);
    if (r > 0) return 2'b01;
    if (r < 0) return 2'b11;
    return 2'b00;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 64; i++) begin
      in_mem[i] = 2'($urandom_range(0, 3));
      w_mem[i]  = 2'($urandom_range(0, 3));
    end
  endtask

  // Must be called right after a negedge; returns at the negedge where done is seen.
  task automatic launch(input int b, input int glitch_at, output int cycles);
    cnt_log.delete();
    nif.bias  = 4'(b);
    nif.start = 1'b1;
    cycles    = 0;
    while (cycles < 200) begin
      @(negedge clk);
      cycles++;
      nif.start = 1'b0;
      cnt_log.push_back(int'(nif.mac_count_out));
      if (glitch_at >= 0 && cycles > 1 && int'(nif.mac_count_out) == glitch_at) begin
        nif.start     = 1'b1;
        glitch_result = nif.result;
      end
      if (nif.done) break;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    cmp_count += 4;
    if (nif.done !== 1'b0) begin err_count++; $display("FAIL reset_done: got %b expected 0", nif.done); end
    if (nif.result !== 7'd0) begin err_count++; $display("FAIL reset_result: got %0d expected 0", $signed(nif.result)); end
    if (nif.act !== 2'b00) begin err_count++; $display("FAIL reset_act: got %b expected 00", nif.act); end
    if (nif.mac_count_out !== 6'd0) begin err_count++; $display("FAIL reset_count: got %0d expected 0", nif.mac_count_out); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    cmp_count += 2;
    if (nif.done !== 1'b0) begin err_count++; $display("FAIL idle_done: got %b expected 0", nif.done); end
    if (nif.mac_count_out !== 6'd0) begin err_count++; $display("FAIL idle_count: got %0d expected 0", nif.mac_count_out); end
  endtask

  task automatic test_directed();
    int bias_tab [6] = '{0, -8, 3, 0, -1, 0};
    int cycles, exp_r;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 64; i++) begin
        case (c)
          0:       begin in_mem[i] = 2'b01; w_mem[i] = 2'b01; end
          1:       begin in_mem[i] = 2'b01; w_mem[i] = 2'b11; end
          2, 3:    begin in_mem[i] = (i % 2 == 1) ? 2'b10 : 2'b00; w_mem[i] = 2'b01; end
          4:       begin in_mem[i] = 2'b01; w_mem[i] = (i % 2 == 1) ? 2'b11 : 2'b01; end
          default: begin in_mem[i] = 2'b01; w_mem[i] = (i % 2 == 1) ? 2'b00 : 2'b01; end
        endcase
      end
      exp_r = model_res(model_acc(bias_tab[c]));
      @(negedge clk);
      launch(bias_tab[c], -1, cycles);
      cmp_count += 3;
      if (cycles != 66) begin err_count++; $display("FAIL directed%0d_latency: got %0d expected 66", c, cycles); end
      if (nif.result !== 7'(exp_r)) begin err_count++; $display("FAIL directed%0d_result: got %0d expected %0d", c, $signed(nif.result), exp_r); end
      if (nif.act !== model_act(exp_r)) begin err_count++; $display("FAIL directed%0d_act: got %b expected %b", c, nif.act, model_act(exp_r)); end
      last_exp = exp_r;
    end
  endtask

  task automatic test_timing();
    int cycles, bad;
    fill_random();
    @(negedge clk);
    launch(2, -1, cycles);
    last_exp = model_res(model_acc(2));
    bad = 0;
    if (cnt_log.size() < 65) bad = 1;
    else begin
      for (int k = 0; k < 64; k++) if (cnt_log[k] != k) bad++;
      if (cnt_log[64] != 0) bad++;
    end
    cmp_count += 3;
    if (cycles != 66) begin err_count++; $display("FAIL timing_latency: got %0d expected 66", cycles); end
    if (bad != 0) begin err_count++; $display("FAIL timing_count_seq: got %0d bad steps expected 0", bad); end
    @(negedge clk);
    if (nif.done !== 1'b0) begin err_count++; $display("FAIL timing_done_width: got %b expected 0", nif.done); end
  endtask

  task automatic test_ignore_start();
    int cycles, prev, exp_r;
    prev = last_exp;
    fill_random();
    exp_r = model_res(model_acc(-3));
    @(negedge clk);
    launch(-3, 10, cycles);
    cmp_count += 4;
    if (glitch_result !== 7'(prev)) begin err_count++; $display("FAIL hold_result: got %0d expected %0d", $signed(glitch_result), prev); end
    if (cycles != 66) begin err_count++; $display("FAIL ignore_latency: got %0d expected 66", cycles); end
    if (nif.result !== 7'(exp_r)) begin err_count++; $display("FAIL ignore_result: got %0d expected %0d", $signed(nif.result), exp_r); end
    repeat (70) @(negedge clk);
    if (nif.mac_count_out !== 6'd0) begin err_count++; $display("FAIL ignore_no_restart: got count %0d expected 0", nif.mac_count_out); end
    last_exp = exp_r;
  endtask

  task automatic test_back_to_back();
    int cycles, exp_a, exp_b;
    fill_random();
    exp_a = model_res(model_acc(5));
    @(negedge clk);
    launch(5, -1, cycles);
    cmp_count += 1;
    if (nif.result !== 7'(exp_a)) begin err_count++; $display("FAIL b2b_first: got %0d expected %0d", $signed(nif.result), exp_a); end
    fill_random();
    exp_b = model_res(model_acc(-6));
    launch(-6, -1, cycles);
    cmp_count += 3;
    if (cycles != 66) begin err_count++; $display("FAIL b2b_latency: got %0d expected 66", cycles); end
    if (nif.result !== 7'(exp_b)) begin err_count++; $display("FAIL b2b_second: got %0d expected %0d", $signed(nif.result), exp_b); end
    if (nif.act !== model_act(exp_b)) begin err_count++; $display("FAIL b2b_act: got %b expected %b", nif.act, model_act(exp_b)); end
    last_exp = exp_b;
  endtask

  task automatic test_random();
    int cycles, b, exp_r;
    for (int n = 0; n < 8; n++) begin
      fill_random();
      b = $urandom_range(0, 15) - 8;
      exp_r = model_res(model_acc(b));
      @(negedge clk);
      launch(b, -1, cycles);
      cmp_count += 2;
      if (nif.result !== 7'(exp_r)) begin err_count++; $display("FAIL random%0d_result: got %0d expected %0d", n, $signed(nif.result), exp_r); end
      if (nif.act !== model_act(exp_r)) begin err_count++; $display("FAIL random%0d_act: got %b expected %b", n, nif.act, model_act(exp_r)); end
      last_exp = exp_r;
    end
  endtask

  task automatic test_reset_mid_run();
    int waited, cycles, exp_r;
    for (int i = 0; i < 64; i++) begin in_mem[i] = 2'b01; w_mem[i] = 2'b01; end
    @(negedge clk);
    nif.bias  = 4'd7;
    nif.start = 1'b1;
    @(negedge clk);
    nif.start = 1'b0;
    waited = 0;
    while (nif.mac_count_out !== 6'd20 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    cmp_count += 1;
    if (waited >= 100) begin err_count++; $display("FAIL mid_reach_20: got timeout expected count 20"); end
    rst_n = 1'b0;
    #1;
    cmp_count += 4;
    if (nif.done !== 1'b0) begin err_count++; $display("FAIL mid_reset_done: got %b expected 0", nif.done); end
    if (nif.result !== 7'd0) begin err_count++; $display("FAIL mid_reset_result: got %0d expected 0", $signed(nif.result)); end
    if (nif.act !== 2'b00) begin err_count++; $display("FAIL mid_reset_act: got %b expected 00", nif.act); end
    if (nif.mac_count_out !== 6'd0) begin err_count++; $display("FAIL mid_reset_count: got %0d expected 0", nif.mac_count_out); end
    @(negedge clk);
    rst_n = 1'b1;
    fill_random();
    exp_r = model_res(model_acc(1));
    @(negedge clk);
    launch(1, -1, cycles);
    cmp_count += 2;
    if (cycles != 66) begin err_count++; $display("FAIL fresh_latency: got %0d expected 66", cycles); end
    if (nif.result !== 7'(exp_r)) begin err_count++; $display("FAIL fresh_result: got %0d expected %0d", $signed(nif.result), exp_r); end
  endtask

  initial begin
    nif.start = 1'b0;
    nif.bias  = 4'd0;
    for (int i = 0; i < 64; i++) begin in_mem[i] = 2'b00; w_mem[i] = 2'b00; end
    glitch_result = '0;
    last_exp = 0;
    test_reset();
    test_directed();
    test_timing();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
